// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 fetch stage.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ILEN_BYTES = 4;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_VALID = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // A PC target is illegal unless it is word-aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack and
// presents the held instruction to decode through valid/ready.
`timescale 1ns/1ps
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misalign_err,
  output logic [XLEN-1:0] instr_count
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_tgt;
  logic            r_err;
  logic [XLEN-1:0] r_cnt;

  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_ir_nxt;
  logic [XLEN-1:0] w_tgt_nxt;
  logic            w_err_nxt;
  logic [XLEN-1:0] w_cnt_nxt;

  logic            w_tgt_bad;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_flush_tgt;
  logic            w_flush_err;

  // Sequential PC step wraps modulo 2^32 by width truncation.
  assign w_pc_inc    = r_pc + XLEN'(ILEN_BYTES);
  assign w_tgt_bad   = is_misaligned(redirect_target[1:0]);
  // In FLUSH a same-cycle redirect is the newest target and wins.
  assign w_flush_tgt = redirect ? redirect_target : r_tgt;
  assign w_flush_err = r_err | (redirect & w_tgt_bad);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= INSTR_NOP;
      r_tgt   <= RESET_PC;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_tgt   <= w_tgt_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_tgt_nxt   = r_tgt;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            // Response already here: drop it and restart at the target.
            if (w_tgt_bad) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_HALT;
            end else begin
              w_pc_nxt = redirect_target;
            end
          end else begin
            // Request still outstanding: park the target and drain.
            w_tgt_nxt   = redirect_target;
            w_err_nxt   = r_err | w_tgt_bad;
            w_state_nxt = ST_FLUSH;
          end
        end else if (imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_state_nxt = ST_VALID;
        end
      end

      ST_VALID: begin
        if (instr_ready) begin
          w_cnt_nxt = r_cnt + XLEN'(1);
        end
        if (redirect) begin
          if (w_tgt_bad) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt    = redirect_target;
            w_state_nxt = ST_FETCH;
          end
        end else if (instr_ready) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FLUSH: begin
        if (redirect) begin
          w_tgt_nxt = redirect_target;
          w_err_nxt = w_flush_err;
        end
        if (imem_ack) begin
          w_pc_nxt    = w_flush_tgt;
          w_state_nxt = w_flush_err ? ST_HALT : ST_FETCH;
        end
      end

      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs come from registers or a state decode only.
  assign imem_req     = (r_state == ST_FETCH) || (r_state == ST_FLUSH);
  assign imem_addr    = r_pc;
  assign instr_valid  = (r_state == ST_VALID);
  assign instr_out    = instr_valid ? r_ir : INSTR_NOP;
  assign pc_out       = r_pc;
  assign misalign_err = r_err;
  assign instr_count  = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a random
// run scored against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misalign_err;
  logic [31:0] instr_count;

  int errors;
  int checks;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .misalign_err    (misalign_err),
    .instr_count     (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image used by the random run: any address yields a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack        = 1'b0;
    imem_rdata      = 32'h0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b valid=%b err=%b, required 0 0 0",
               imem_req, instr_valid, misalign_err);
    end
    checks++;
    if (instr_count !== 32'h0 || pc_out !== 32'h0 || instr_out !== NOP) begin
      errors++;
      $display("FAIL reset_data: count=%h pc=%h instr=%h, required 0 0 %h",
               instr_count, pc_out, instr_out, NOP);
    end
    rst_n = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle: req=%b, required 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_req%0d: req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, 32'(4 * i));
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'h00A0_0093;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'(4 * i) || instr_out !== 32'h00A0_0093) begin
        errors++;
        $display("FAIL seq_valid%0d: valid=%b pc=%h instr=%h, required 1 %h 00a00093",
                 i, instr_valid, pc_out, instr_out, 32'(4 * i));
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
    end
    checks++;
    if (instr_count !== 32'd3) begin
      errors++;
      $display("FAIL seq_count: count=%0d, required 3", instr_count);
    end
  endtask

  task automatic test_hold();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'h0C || instr_out !== 32'h1111_1111 ||
          imem_req !== 1'b0 || instr_count !== 32'd3) begin
        errors++;
        $display("FAIL hold%0d: valid=%b pc=%h instr=%h req=%b count=%0d, required 1 0000000c 11111111 0 3",
                 i, instr_valid, pc_out, instr_out, imem_req, instr_count);
      end
      step();
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (instr_count !== 32'd4 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL hold_release: count=%0d req=%b addr=%h, required 4 1 00000010",
               instr_count, imem_req, imem_addr);
    end
  endtask

  task automatic test_flush();
    redirect        = 1'b1;
    redirect_target = 32'h100;
    step();
    redirect = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_hold%0d: req=%b addr=%h valid=%b, required 1 00000010 0",
                 i, imem_req, imem_addr, instr_valid);
      end
      if (i < 3) step();
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL flush_done: valid=%b instr=%h req=%b addr=%h, required 0 %h 1 00000100",
               instr_valid, instr_out, imem_req, imem_addr, NOP);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h2222_2222;
    step();
    imem_ack   = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instr_out !== 32'h2222_2222) begin
      errors++;
      $display("FAIL flush_target: valid=%b pc=%h instr=%h, required 1 00000100 22222222",
               instr_valid, pc_out, instr_out);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_double_redirect();
    redirect        = 1'b1;
    redirect_target = 32'h200;
    step();
    redirect_target = 32'h300;
    step();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL dbl_stale: req=%b addr=%h, required 1 00000104", imem_req, imem_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hBADB_AD00;
    step();
    imem_ack   = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL dbl_newest: req=%b addr=%h, required 1 00000300", imem_req, imem_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h3333_3333;
    step();
    imem_ack   = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h300 || instr_out !== 32'h3333_3333) begin
      errors++;
      $display("FAIL dbl_data: valid=%b pc=%h instr=%h, required 1 00000300 33333333",
               instr_valid, pc_out, instr_out);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_ready();
    // Redirect with a same-cycle ack: restart at the target next cycle.
    redirect        = 1'b1;
    redirect_target = 32'h40;
    imem_ack        = 1'b1;
    imem_rdata      = 32'h0BAD_0BAD;
    step();
    idle_inputs();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdr_ack: req=%b addr=%h valid=%b, required 1 00000040 0",
               imem_req, imem_addr, instr_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h4444_4444;
    step();
    imem_ack   = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h40 || instr_out !== 32'h4444_4444) begin
      errors++;
      $display("FAIL rdr_valid: valid=%b pc=%h instr=%h, required 1 00000040 44444444",
               instr_valid, pc_out, instr_out);
    end
    instr_ready     = 1'b1;
    redirect        = 1'b1;
    redirect_target = 32'h80;
    step();
    idle_inputs();
    checks++;
    if (instr_count !== 32'd7 || imem_req !== 1'b1 || imem_addr !== 32'h80 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdr_retire: count=%0d req=%b addr=%h valid=%b, required 7 1 00000080 0",
               instr_count, imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_misalign();
    redirect        = 1'b1;
    redirect_target = 32'h102;
    step();
    redirect = 1'b0;
    checks++;
    if (misalign_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      errors++;
      $display("FAIL mis_drain: err=%b req=%b addr=%h, required 1 1 00000080",
               misalign_err, imem_req, imem_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_5555;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b1 || instr_count !== 32'd7) begin
        errors++;
        $display("FAIL mis_halt%0d: req=%b valid=%b err=%b count=%0d, required 0 0 1 7",
                 i, imem_req, instr_valid, misalign_err, instr_count);
      end
      redirect        = 1'b1;
      redirect_target = 32'h0;
      instr_ready     = 1'b1;
      step();
    end
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (misalign_err !== 1'b0 || pc_out !== 32'h0 || instr_count !== 32'h0) begin
      errors++;
      $display("FAIL mis_reset: err=%b pc=%h count=%0d, required 0 00000000 0",
               misalign_err, pc_out, instr_count);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL mis_recover: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
    // Misaligned redirect from VALID halts without another request.
    imem_ack   = 1'b1;
    imem_rdata = 32'h6666_6666;
    step();
    imem_ack        = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h1FE;
    step();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL mis_valid: req=%b valid=%b err=%b, required 0 0 1",
               imem_req, instr_valid, misalign_err);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    logic [31:0] tgt;
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    exp_pc    = 32'h0;
    exp_cnt   = 32'h0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Observe the settled outputs against the model.
      checks++;
      if (instr_valid === 1'b1) begin
        if (pc_out !== exp_pc || instr_out !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rnd_instr c%0d: pc=%h instr=%h, required %h %h",
                   cyc, pc_out, instr_out, exp_pc, mem_word(exp_pc));
        end
      end else if (instr_out !== NOP) begin
        errors++;
        $display("FAIL rnd_nop c%0d: instr=%h, required %h", cyc, instr_out, NOP);
      end
      checks++;
      if (instr_count !== exp_cnt || misalign_err !== 1'b0) begin
        errors++;
        $display("FAIL rnd_count c%0d: count=%0d err=%b, required %0d 0",
                 cyc, instr_count, misalign_err, exp_cnt);
      end
      if (prev_req && !prev_ack && imem_req) begin
        checks++;
        if (imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL rnd_addr_stable c%0d: addr=%h, required %h", cyc, imem_addr, prev_addr);
        end
      end
      // Drive the next cycle's inputs.
      imem_ack    = imem_req && ($urandom_range(0, 2) == 0);
      imem_rdata  = imem_ack ? mem_word(imem_addr) : $urandom;
      instr_ready = ($urandom_range(0, 1) == 1);
      redirect    = (cyc > 0) && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8;
      else tgt = 32'($urandom_range(0, 255)) << 2;
      redirect_target = redirect ? tgt : $urandom;
      // Model: next delivered instruction is the newest redirect target,
      // otherwise the one after the last accepted instruction.
      if (instr_valid && instr_ready) exp_cnt = exp_cnt + 32'd1;
      if (redirect) exp_pc = tgt;
      else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      step();
    end
    idle_inputs();
    checks++;
    if (instr_count === 32'h0) begin
      errors++;
      $display("FAIL rnd_progress: count=%0d, required nonzero", instr_count);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_hold();
    test_flush();
    test_double_redirect();
    test_redirect_ready();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
